multicycle_control_unit: RTL

- Multi-cycle successor to the single-cycle main decoder. It sequences each RV32I instruction (lw, sw, R-type, I-type ALU, jal, beq/bne) through a Moore FSM that drives a shared-ALU, single-memory datapath.
- Adds a memory ready handshake (stalls), illegal-opcode trapping with an optional halt, and a retired-instruction counter.
- Sits between the instruction register (supplies op/funct3), the ALU (supplies zero) and the unified instruction/data memory. ALUOp feeds the existing ALU decoder unchanged.

---
 rtl/multicycle_control_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences each instruction over a shared ALU
// and unified memory, with memory stalls, illegal-opcode trap and instret.
module multicycle_control_unit #(
    parameter int CNT_W      = 32,
    parameter bit ENABLE_BNE = 1'b1,
    parameter bit TRAP_HALT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ResultSrc,
    output logic             illegal_instr,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_ALUWB,
        S_BRANCH,
        S_ILLEGAL
    } state_t;

    state_t state;
    state_t state_next;
    logic   taken;
    logic   retire;

    assign taken = zero ^ (ENABLE_BNE && (funct3 == 3'b001));

    // MEMWRITE only completes (and retires) once memory accepts the store
    assign retire = (state == S_MEMWB) || (state == S_ALUWB) ||
                    (state == S_BRANCH) ||
                    ((state == S_MEMWRITE) && mem_ready);

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH:         state_next = S_BRANCH;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_ILLEGAL:  state_next = TRAP_HALT ? S_ILLEGAL : S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_next;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        ImmSrc        = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        ResultSrc     = 2'b00;
        illegal_instr = 1'b0;
        halted        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ImmSrc  = 2'b11;
                PCWrite = 1'b1;
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                ImmSrc  = 2'b10;
                PCWrite = taken;
            end
            S_ILLEGAL: begin
                illegal_instr = 1'b1;
                halted        = TRAP_HALT;
            end
            default: ;
        endcase
        // reset shows the FETCH datapath selects with every enable held low
        if (reset) begin
            mem_req       = 1'b0;
            AdrSrc        = 1'b0;
            IRWrite       = 1'b0;
            PCWrite       = 1'b0;
            MemWrite      = 1'b0;
            RegWrite      = 1'b0;
            ImmSrc        = 2'b00;
            ALUSrcA       = 2'b00;
            ALUSrcB       = 2'b10;
            ALUOp         = 2'b00;
            ResultSrc     = 2'b10;
            illegal_instr = 1'b0;
            halted        = 1'b0;
        end
    end

endmodule
